assoc_cache_ctrl: RTL and testbench
===================================

# assoc_cache_ctrl

Parametrised N-way set-associative, write-through, no-write-allocate cache controller sitting between the MEM pipeline stage and the line-wide SRAM controller. Generalises the fixed-geometry cache controller: way count, set count and line size are parameters, replacement is tree pseudo-LRU, and it adds a whole-cache flush sequence and hit/miss counters. `ready` low freezes the pipeline; the MEM stage holds its request stable until `ready` returns high.

## Interface
- `ADDR_W`, 32: byte address width.
- `DATA_W`, 32: word width.
- `WAYS`, 2: associativity; legal values 1, 2, 4.
- `SETS`, 64: set count; power of two, ≥2.
- `LINE_WORDS`, 2: words per line; power of two; SRAM read port is `LINE_WORDS*DATA_W` wide.
- `CNT_W`, 32: statistics counter width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `addr` in ADDR_W: byte address (word-aligned).
- `write_data` in DATA_W: store value.
- `mem_read_enable` in 1: load request.
- `mem_write_enable` in 1: store request.
- `flush` in 1: invalidate-all request, one-cycle pulse.
- `read_data` out DATA_W: load result, valid when `ready` and `mem_read_enable`.
- `ready` out 1: access complete / controller idle.
- `sram_addr` out ADDR_W: line-aligned address (reads) or word address (writes).
- `sram_write_data` out DATA_W: store value to SRAM.
- `sram_write_en`, `sram_read_en` out 1: SRAM requests, held until `sram_ready`.
- `sram_read_data` in LINE_WORDS*DATA_W: fetched line, word 0 in LSBs.
- `sram_ready` in 1: SRAM access done, one-cycle pulse.
- `hit_count`, `miss_count` out CNT_W: saturating load hit/miss counters.

## Operation
- Address split: offset = `addr[2 +: log2(LINE_WORDS)]`, index = next `log2(SETS)` bits, tag = remaining upper bits.
- Storage per set: per way valid bit, tag, LINE_WORDS data words; per set WAYS-1 PLRU bits (none when WAYS=1).
- FSM states: IDLE, READ_MISS, WRITE, FLUSH.
- IDLE, load hit (any valid way with matching tag): `ready`=1 and `read_data` = selected word combinationally in the same cycle; PLRU updated to point away from hit way; `hit_count`+1.
- IDLE, load miss: `ready`=0, go READ_MISS, `sram_read_en`=1, `sram_addr` = line-aligned address; `miss_count`+1 once per miss.
- READ_MISS: wait for `sram_ready`; that cycle: fill victim way (first invalid way, lowest index first, else PLRU victim), set valid/tag, update PLRU, `read_data` = requested word from `sram_read_data`, `ready`=1, return to IDLE.
- IDLE, store: go WRITE, `sram_write_en`=1, `sram_addr`=`addr`. On `sram_ready`: if tag hits, update that word in the cache and PLRU; miss allocates nothing; `ready`=1, return to IDLE.
- Read and write enables both high: treated as store.
- `flush` in IDLE with no request: go FLUSH, clear valid and PLRU of one set per cycle, index 0 to SETS-1, `ready`=0, then IDLE. `flush` arriving with a request, or while busy: latched, serviced on the next IDLE cycle with no pending request.
- Counters saturate at all-ones; not cleared by flush.

## Timing
- Reset (async, `rst`=0): state IDLE, all valid and PLRU bits cleared, `sram_*_en`=0, `sram_addr`=0, `sram_write_data`=0, counters 0, flush latch 0. Combinational outputs with no request: `ready`=1, `read_data`=0.
- Load hit latency 0 cycles; load miss = SRAM latency + 1 cycle (detect cycle); store = SRAM latency + 1 cycle.
- `sram_read_en`/`sram_write_en` are registered, high from the cycle after detection until the `sram_ready` cycle inclusive, deasserted the next cycle.
- Reset mid-access: abandon transaction immediately; no partial fill.
- Flush takes exactly SETS cycles.
- Index wrap in FLUSH: counter of log2(SETS) bits, exit on all-ones.

## Structure
- Shared package: state encoding enum, `clog2`-derived widths (OFFSET_W, INDEX_W, TAG_W), PLRU helper functions (victim select, update).
- One sub-module: `plru_tree` (per-set PLRU bits in, accessed way in, updated bits and victim way out), instantiated once combinationally.

## Test plan
- Reset, load 0x100 (cold): `sram_read_en` next cycle, `sram_addr`=0x100; after `sram_ready` with line {0xBBBB,0xAAAA}, `read_data`=0xAAAA, `miss_count`=1.
- Reload 0x104: `ready`=1 same cycle, `read_data`=0xBBBB, `hit_count`=1, no SRAM access.
- WAYS=2, SETS=64, LINE_WORDS=2: loads 0x000, 0x200, then 0x000 again, then 0x400 → 0x200 evicted (PLRU); reload 0x000 hits, 0x200 misses.
- Store 0x104=0x1234 after fill: `sram_write_en` until `sram_ready`; following load 0x104 hits with 0x1234; store to uncached 0x800 then load 0x800 misses.
- Load hit, pulse `flush`, wait 64 cycles with `ready`=0; same load then misses; counters unchanged by flush.
- `rst` low during READ_MISS: `sram_read_en` drops immediately, `ready`=1, first load after reset misses.

Source files
------------

// File: rtl/assoc_cache_ctrl_pkg.sv
// rtl/assoc_cache_ctrl_pkg.sv - shared types, width helpers and PLRU functions for assoc_cache_ctrl
package assoc_cache_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_READ_MISS = 2'd1,
    S_WRITE     = 2'd2,
    S_FLUSH     = 2'd3
  } state_t;

  // Widest PLRU tree / way index supported (WAYS up to 4)
  localparam int PLRU_MAX_W = 3;
  localparam int WAY_MAX_W  = 2;

  function automatic int offset_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int line_words, input int sets);
    return addr_w - 2 - $clog2(line_words) - $clog2(sets);
  endfunction

  // Way index width, kept at least one bit so direct-mapped builds stay legal
  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  // PLRU storage width per set, kept at least one bit
  function automatic int plru_w(input int ways);
    return (ways > 1) ? ways - 1 : 1;
  endfunction

  // Tree bits name the least-recently-used side: bit0 is the root,
  // bit1 chooses inside ways 0/1, bit2 chooses inside ways 2/3.
  function automatic logic [WAY_MAX_W-1:0] plru_victim(input logic [PLRU_MAX_W-1:0] bits,
                                                       input int ways);
    logic [WAY_MAX_W-1:0] v;
    v = '0;
    if (ways == 4) begin
      v = bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
    end else if (ways == 2) begin
      v = {1'b0, bits[0]};
    end
    return v;
  endfunction

  // Point every tree node on the accessed path away from the accessed way
  function automatic logic [PLRU_MAX_W-1:0] plru_update(input logic [PLRU_MAX_W-1:0] bits,
                                                        input logic [WAY_MAX_W-1:0] way,
                                                        input int ways);
    logic [PLRU_MAX_W-1:0] b;
    b = bits;
    if (ways == 4) begin
      b[0] = ~way[1];
      if (way[1]) b[2] = ~way[0];
      else        b[1] = ~way[0];
    end else if (ways == 2) begin
      b[0] = ~way[0];
    end
    return b;
  endfunction

endpackage

// File: rtl/assoc_cache_ctrl_plru_tree.sv
// rtl/assoc_cache_ctrl_plru_tree.sv - combinational tree pseudo-LRU update and victim select
module plru_tree
  import assoc_cache_ctrl_pkg::*;
#(
  parameter int WAYS   = 2,
  parameter int PLRU_W = 1,
  parameter int WAY_W  = 1
) (
  input  logic [PLRU_W-1:0] bits_in,
  input  logic [WAY_W-1:0]  way_in,
  output logic [PLRU_W-1:0] bits_out,
  output logic [WAY_W-1:0]  victim
);

  logic [PLRU_MAX_W-1:0] bits_ext;
  logic [WAY_MAX_W-1:0]  way_ext;

  // Widen to the largest tree, evaluate, and narrow back to this geometry
  always_comb begin
    bits_ext = PLRU_MAX_W'(bits_in);
    way_ext  = WAY_MAX_W'(way_in);
    bits_out = PLRU_W'(plru_update(bits_ext, way_ext, WAYS));
    victim   = WAY_W'(plru_victim(bits_ext, WAYS));
  end

endmodule

// File: rtl/assoc_cache_ctrl.sv
// rtl/assoc_cache_ctrl.sv - N-way write-through no-write-allocate cache controller with PLRU and flush
module assoc_cache_ctrl
  import assoc_cache_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 2,
  parameter int CNT_W      = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            write_data,
  input  logic                         mem_read_enable,
  input  logic                         mem_write_enable,
  input  logic                         flush,
  output logic [DATA_W-1:0]            read_data,
  output logic                         ready,
  output logic [ADDR_W-1:0]            sram_addr,
  output logic [DATA_W-1:0]            sram_write_data,
  output logic                         sram_write_en,
  output logic                         sram_read_en,
  input  logic [LINE_WORDS*DATA_W-1:0] sram_read_data,
  input  logic                         sram_ready,
  output logic [CNT_W-1:0]             hit_count,
  output logic [CNT_W-1:0]             miss_count
);

  localparam int OFFSET_W = offset_w(LINE_WORDS);
  localparam int INDEX_W  = index_w(SETS);
  localparam int TAG_W    = tag_w(ADDR_W, LINE_WORDS, SETS);
  localparam int WAY_W    = way_w(WAYS);
  localparam int PLRU_W   = plru_w(WAYS);
  localparam int OFF_W    = (OFFSET_W > 0) ? OFFSET_W : 1;
  localparam int LINE_W   = LINE_WORDS * DATA_W;

  // Cache storage
  logic [WAYS-1:0]   valid_q [SETS];
  logic [PLRU_W-1:0] plru_q  [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];

  state_t             state_q, state_d;
  logic               flush_pend_q, flush_pend_d;
  logic [INDEX_W-1:0] flush_idx_q, flush_idx_d;
  logic               rd_en_d, wr_en_d;
  logic [ADDR_W-1:0]  saddr_d;
  logic [DATA_W-1:0]  swdata_d;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [OFF_W-1:0]   off;
  logic [ADDR_W-1:0]  line_addr;

  logic               hit, has_inv;
  logic [WAY_W-1:0]   hit_way, inv_way, plru_victim_way, victim_way, acc_way;
  logic [PLRU_W-1:0]  plru_next;
  logic [LINE_W-1:0]  hit_line;
  logic [DATA_W-1:0]  hit_word, miss_word;

  logic hit_inc, miss_inc, fill, wr_hit, rd_hit_upd, flush_clr;

  // Split the byte address into line offset, set index and tag
  always_comb begin
    idx       = addr[2+OFFSET_W +: INDEX_W];
    tag       = addr[ADDR_W-1 -: TAG_W];
    off       = (LINE_WORDS > 1) ? addr[2 +: OFF_W] : '0;
    line_addr = addr & ~ADDR_W'(LINE_WORDS * 4 - 1);
  end

  // Tag compare across the set; also find the lowest-numbered invalid way
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  // Fills go to the accessed set's victim; hits touch the hit way
  always_comb begin
    victim_way = has_inv ? inv_way : plru_victim_way;
    acc_way    = (state_q == S_READ_MISS) ? victim_way : hit_way;
    hit_line   = data_q[idx][hit_way];
    hit_word   = hit_line[off*DATA_W +: DATA_W];
    miss_word  = sram_read_data[off*DATA_W +: DATA_W];
  end

  plru_tree #(
    .WAYS   (WAYS),
    .PLRU_W (PLRU_W),
    .WAY_W  (WAY_W)
  ) u_plru_tree (
    .bits_in  (plru_q[idx]),
    .way_in   (acc_way),
    .bits_out (plru_next),
    .victim   (plru_victim_way)
  );

  // Next-state, combinational responses and update strobes
  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q | flush;
    flush_idx_d  = flush_idx_q;
    rd_en_d      = sram_read_en;
    wr_en_d      = sram_write_en;
    saddr_d      = sram_addr;
    swdata_d     = sram_write_data;
    ready        = 1'b0;
    read_data    = '0;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;
    fill         = 1'b0;
    wr_hit       = 1'b0;
    rd_hit_upd   = 1'b0;
    flush_clr    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_write_enable) begin
          state_d  = S_WRITE;
          wr_en_d  = 1'b1;
          saddr_d  = addr;
          swdata_d = write_data;
        end else if (mem_read_enable) begin
          if (hit) begin
            ready      = 1'b1;
            read_data  = hit_word;
            hit_inc    = 1'b1;
            rd_hit_upd = 1'b1;
          end else begin
            state_d  = S_READ_MISS;
            rd_en_d  = 1'b1;
            saddr_d  = line_addr;
            miss_inc = 1'b1;
          end
        end else begin
          ready = 1'b1;
          if (flush || flush_pend_q) begin
            state_d      = S_FLUSH;
            flush_pend_d = 1'b0;
            flush_idx_d  = '0;
          end
        end
      end
      S_READ_MISS: begin
        if (sram_ready) begin
          ready     = 1'b1;
          read_data = miss_word;
          fill      = 1'b1;
          rd_en_d   = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_WRITE: begin
        if (sram_ready) begin
          ready   = 1'b1;
          wr_hit  = hit;
          wr_en_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        flush_clr   = 1'b1;
        flush_idx_d = flush_idx_q + INDEX_W'(1);
        if (flush_idx_q == '1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, SRAM request registers, counters, valid and PLRU bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      flush_pend_q    <= 1'b0;
      flush_idx_q     <= '0;
      sram_read_en    <= 1'b0;
      sram_write_en   <= 1'b0;
      sram_addr       <= '0;
      sram_write_data <= '0;
      hit_count       <= '0;
      miss_count      <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q         <= state_d;
      flush_pend_q    <= flush_pend_d;
      flush_idx_q     <= flush_idx_d;
      sram_read_en    <= rd_en_d;
      sram_write_en   <= wr_en_d;
      sram_addr       <= saddr_d;
      sram_write_data <= swdata_d;
      if (hit_inc && (hit_count != '1))   hit_count  <= hit_count + CNT_W'(1);
      if (miss_inc && (miss_count != '1)) miss_count <= miss_count + CNT_W'(1);
      if (flush_clr) begin
        valid_q[flush_idx_q] <= '0;
        plru_q[flush_idx_q]  <= '0;
      end
      if (fill) begin
        valid_q[idx][victim_way] <= 1'b1;
        plru_q[idx]              <= plru_next;
      end
      if (rd_hit_upd || wr_hit) plru_q[idx] <= plru_next;
    end
  end

  // Line data and tags need no reset: valid bits gate every use
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[idx][victim_way]  <= tag;
      data_q[idx][victim_way] <= sram_read_data;
    end
    if (wr_hit) data_q[idx][hit_way][off*DATA_W +: DATA_W] <= write_data;
  end

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// tb/tb_assoc_cache_ctrl.sv - directed table-driven bench for assoc_cache_ctrl
module tb_assoc_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic        flush;
  logic [31:0] read_data;
  logic        ready;
  logic [31:0] sram_addr;
  logic [31:0] sram_write_data;
  logic        sram_write_en;
  logic        sram_read_en;
  logic [63:0] sram_read_data;
  logic        sram_ready;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        st;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [63:0] line;
    logic        miss;
    logic [31:0] rdata;
    logic [31:0] saddr;
    int          hits;
    int          misses;
  } vec_t;

  vec_t tbl[14];

  assoc_cache_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .addr             (addr),
    .write_data       (write_data),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .flush            (flush),
    .read_data        (read_data),
    .ready            (ready),
    .sram_addr        (sram_addr),
    .sram_write_data  (sram_write_data),
    .sram_write_en    (sram_write_en),
    .sram_read_en     (sram_read_en),
    .sram_read_data   (sram_read_data),
    .sram_ready       (sram_ready),
    .hit_count        (hit_count),
    .miss_count       (miss_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    flush            = 1'b0;
  endtask

  // One load or store; SRAM answers two cycles after the request appears
  task automatic run_access(input vec_t v, input string tag);
    @(negedge clk);
    mem_read_enable  = !v.st;
    mem_write_enable = v.st;
    addr             = v.addr;
    write_data       = v.wdata;
    #1;
    if (!v.miss) begin
      check({tag, " hit ready"}, 64'(ready), 64'd1);
      check({tag, " hit rdata"}, 64'(read_data), 64'(v.rdata));
      check({tag, " hit no sram"}, 64'({sram_read_en, sram_write_en}), 64'd0);
      @(negedge clk);
      idle_inputs();
    end else begin
      check({tag, " detect ready"}, 64'(ready), 64'd0);
      @(negedge clk);
      check({tag, " sram en"}, 64'(v.st ? sram_write_en : sram_read_en), 64'd1);
      check({tag, " sram addr"}, 64'(sram_addr), 64'(v.saddr));
      if (v.st) check({tag, " sram wdata"}, 64'(sram_write_data), 64'(v.wdata));
      @(negedge clk);
      check({tag, " en held"}, 64'(v.st ? sram_write_en : sram_read_en), 64'd1);
      sram_ready     = 1'b1;
      sram_read_data = v.line;
      #1;
      check({tag, " done ready"}, 64'(ready), 64'd1);
      if (!v.st) check({tag, " fill rdata"}, 64'(read_data), 64'(v.rdata));
      @(negedge clk);
      sram_ready     = 1'b0;
      sram_read_data = '0;
      idle_inputs();
      #1;
      check({tag, " en dropped"}, 64'({sram_read_en, sram_write_en}), 64'd0);
    end
    check({tag, " hit_count"}, 64'(hit_count), 64'(v.hits));
    check({tag, " miss_count"}, 64'(miss_count), 64'(v.misses));
  endtask

  // Count cycles with ready low, bounded, starting from a sampled point
  task automatic count_busy(output int cnt);
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      if (ready) break;
      cnt++;
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    vec_t v;
    int   busy;

    //        st    addr          wdata         line                      miss  rdata         saddr         hits misses
    tbl[0]  = '{1'b0, 32'h0000_0100, 32'h0, 64'h0000BBBB_0000AAAA, 1'b1, 32'h0000_AAAA, 32'h0000_0100, 0, 1};
    tbl[1]  = '{1'b0, 32'h0000_0104, 32'h0, 64'h0,                 1'b0, 32'h0000_BBBB, 32'h0,         1, 1};
    tbl[2]  = '{1'b0, 32'h0000_0000, 32'h0, 64'h00000011_00000010, 1'b1, 32'h0000_0010, 32'h0000_0000, 1, 2};
    tbl[3]  = '{1'b0, 32'h0000_0200, 32'h0, 64'h00000021_00000020, 1'b1, 32'h0000_0020, 32'h0000_0200, 1, 3};
    tbl[4]  = '{1'b0, 32'h0000_0000, 32'h0, 64'h0,                 1'b0, 32'h0000_0010, 32'h0,         2, 3};
    tbl[5]  = '{1'b0, 32'h0000_0404, 32'h0, 64'h00000041_00000040, 1'b1, 32'h0000_0041, 32'h0000_0400, 2, 4};
    tbl[6]  = '{1'b0, 32'h0000_0004, 32'h0, 64'h0,                 1'b0, 32'h0000_0011, 32'h0,         3, 4};
    tbl[7]  = '{1'b0, 32'h0000_0200, 32'h0, 64'h00000021_00000020, 1'b1, 32'h0000_0020, 32'h0000_0200, 3, 5};
    tbl[8]  = '{1'b1, 32'h0000_0104, 32'h0000_1234, 64'h0,         1'b1, 32'h0,         32'h0000_0104, 3, 5};
    tbl[9]  = '{1'b0, 32'h0000_0104, 32'h0, 64'h0,                 1'b0, 32'h0000_1234, 32'h0,         4, 5};
    tbl[10] = '{1'b0, 32'h0000_0100, 32'h0, 64'h0,                 1'b0, 32'h0000_AAAA, 32'h0,         5, 5};
    tbl[11] = '{1'b1, 32'h0000_0800, 32'h0000_5555, 64'h0,         1'b1, 32'h0,         32'h0000_0800, 5, 5};
    tbl[12] = '{1'b0, 32'h0000_0800, 32'h0, 64'h00000081_00000080, 1'b1, 32'h0000_0080, 32'h0000_0800, 5, 6};
    tbl[13] = '{1'b0, 32'h0000_0200, 32'h0, 64'h0,                 1'b0, 32'h0000_0020, 32'h0,         6, 6};

    rst            = 1'b0;
    addr           = '0;
    write_data     = '0;
    sram_read_data = '0;
    sram_ready     = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset ready", 64'(ready), 64'd1);
    check("reset read_data", 64'(read_data), 64'd0);
    check("reset sram en", 64'({sram_read_en, sram_write_en}), 64'd0);
    check("reset sram_addr", 64'(sram_addr), 64'd0);
    check("reset sram_write_data", 64'(sram_write_data), 64'd0);
    check("reset counters", 64'({hit_count, miss_count}), 64'd0);

    for (int i = 0; i < 14; i++) run_access(tbl[i], $sformatf("v%0d", i));

    // Flush from idle: exactly 64 busy cycles, then a former hit misses
    v = '{1'b0, 32'h0000_0100, 32'h0, 64'h0, 1'b0, 32'h0000_AAAA, 32'h0, 7, 6};
    run_access(v, "pre-flush");
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush pulse ready", 64'(ready), 64'd1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    count_busy(busy);
    check("flush busy cycles", 64'(busy), 64'd64);
    check("flush keeps counters", 64'({hit_count, miss_count}), {32'd7, 32'd6});
    v = '{1'b0, 32'h0000_0100, 32'h0, 64'h0000BBBB_0000AAAA, 1'b1, 32'h0000_AAAA, 32'h0000_0100, 7, 7};
    run_access(v, "post-flush");

    // Flush arriving with a load is held until the next idle cycle
    @(negedge clk);
    mem_read_enable = 1'b1;
    addr            = 32'h0000_0100;
    flush           = 1'b1;
    #1;
    check("latched flush load ready", 64'(ready), 64'd1);
    check("latched flush load rdata", 64'(read_data), 64'h0000_AAAA);
    @(negedge clk);
    idle_inputs();
    #1;
    check("latched flush idle ready", 64'(ready), 64'd1);
    @(negedge clk);
    #1;
    count_busy(busy);
    check("latched flush busy cycles", 64'(busy), 64'd64);
    v = '{1'b0, 32'h0000_0100, 32'h0, 64'h0000BBBB_0000AAAA, 1'b1, 32'h0000_AAAA, 32'h0000_0100, 8, 8};
    run_access(v, "after latched flush");

    // Reset in the middle of a miss abandons it
    @(negedge clk);
    mem_read_enable = 1'b1;
    addr            = 32'h0000_0300;
    @(negedge clk);
    check("mid-miss sram_read_en", 64'(sram_read_en), 64'd1);
    mem_read_enable = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check("reset drops sram_read_en", 64'(sram_read_en), 64'd0);
    check("reset ready", 64'(ready), 64'd1);
    check("reset clears counters", 64'({hit_count, miss_count}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    v = '{1'b0, 32'h0000_0100, 32'h0, 64'h0000BBBB_0000AAAA, 1'b1, 32'h0000_AAAA, 32'h0000_0100, 0, 1};
    run_access(v, "after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
